// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the RV32M divide sequencer
package divider_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: BITS_PER_CYCLE chained restoring-division steps, purely combinational
module divider_step #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [31:0] dvd,
  input  logic [31:0] rem,
  input  logic [31:0] q,
  input  logic [31:0] dvs,
  output logic [31:0] nd,
  output logic [31:0] nr,
  output logic [31:0] nq
);
  logic [32:0] t;
  logic ge;
  always_comb begin
    nd = dvd;
    nr = rem;
    nq = q;
    t = '0;
    ge = 1'b0;
    // compare on 33 bits so divisors above 2^31 never lose the shifted-out remainder bit
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      t = {nr, nd[31]};
      nd = nd << 1;
      ge = t >= {1'b0, dvs};
      t = ge ? t - {1'b0, dvs} : t;
      nr = t[31:0];
      nq = {nq[30:0], ge};
    end
  end
endmodule

// File: rtl/divider_sequencer.sv
// divider_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU controller; DIV_FASTPATH_EN skips iteration for div-by-zero/overflow
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  div_op_e          i_op,
  input  logic [31:0]      i_dividend,
  input  logic [31:0]      i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag
);
  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  div_state_e state, state_n;
  div_op_e op;
  logic [TAG_W-1:0] tag;
  logic [31:0] orig, dvd, dvs, rem, q, nd, nr, nq, qf, rf;
  logic [5:0] cnt;
  logic neg_q, neg_r, dz, ovf, acc, sgn, dz_in, ovf_in, fast, last;
  assign sgn = !i_op[0];
  assign dz_in = i_divisor == '0;
  assign ovf_in = sgn && i_dividend == INT_MIN && i_divisor == NEG_ONE;
  assign acc = i_valid && state == IDLE && !i_flush;
  assign last = cnt == 6'(ITERS - 1);
`ifdef DIV_FASTPATH_EN
  assign fast = dz_in || ovf_in;
`else
  assign fast = 1'b0;
`endif
  divider_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .dvd(dvd), .rem(rem), .q(q), .dvs(dvs), .nd(nd), .nr(nr), .nq(nq)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
    state_n = i_flush ? IDLE
            : state == IDLE ? (acc ? (fast ? DONE : BUSY) : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : (i_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= DIV;
      tag <= '0;
      orig <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
    end else if (acc) begin
      op <= i_op;
      tag <= i_tag;
      orig <= i_dividend;
      dvd <= abs32(i_dividend, sgn);
      dvs <= abs32(i_divisor, sgn);
      neg_q <= sgn && (i_dividend[31] ^ i_divisor[31]);
      neg_r <= sgn && i_dividend[31];
      dz <= dz_in;
      ovf <= ovf_in;
      rem <= '0;
      q <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      dvd <= nd;
      rem <= nr;
      q <= nq;
      cnt <= cnt + 6'd1;
    end
  end
  // special cases override whatever the iteration left behind, so the fast path needs no steps
  assign qf = dz ? NEG_ONE : ovf ? INT_MIN : neg_q ? -q : q;
  assign rf = dz ? orig : ovf ? '0 : neg_r ? -rem : rem;
  assign o_result = op[1] ? rf : qf;
  assign o_tag = tag;
endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: scoreboard bench for divider_sequencer (BITS_PER_CYCLE=4)
module tb_divider_sequencer;
  import divider_pkg::*;
  localparam int BPC = 4;
  localparam int ITERS = 32 / BPC;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          c0;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1, i_valid = 0, i_flush = 0, i_ready = 1;
  logic o_ready, o_valid;
  div_op_e i_op = DIV;
  logic [31:0] i_dividend = '0, i_divisor = '0, o_result;
  logic [4:0] i_tag = '0, o_tag;
  int cyc = 0, n_tests = 0, n_fail = 0;
  logic pv = 0;
  exp_t sb[$];
  divider_sequencer #(.BITS_PER_CYCLE(BPC), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      DIV:  return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      REM:  return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return ITERS + 1;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && !pv) begin
        if (sb.size() == 0) chk("spurious_valid", {31'b0, o_valid}, 32'h0);
        else chk("latency", 32'(cyc - sb[0].c0), 32'(sb[0].lat));
      end
      if (o_valid && i_ready && sb.size() != 0) begin
        chk("result", o_result, sb[0].res);
        chk("tag", {27'b0, o_tag}, {27'b0, sb[0].tag});
        void'(sb.pop_front());
      end
    end
    pv = o_valid;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit track);
    int n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    if (!o_ready) chk("ready_timeout", {31'b0, o_ready}, 32'h1);
    i_valid = 1;
    i_op = op;
    i_dividend = a;
    i_divisor = b;
    i_tag = tag;
    if (track) sb.push_back('{model(op, a, b), tag, cyc, exp_lat(op, a, b)});
    tick();
    i_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk("rst_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_result", o_result, 32'h0);
    chk("rst_tag", {27'b0, o_tag}, 32'h0);
    rst = 0;
    tick();
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 1);
    issue(REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 1);
    issue(DIVU, 32'hFFFF_FFFF, 32'h10, 5'd3, 1);
    issue(REMU, 32'hFFFF_FFFF, 32'h10, 5'd4, 1);
    issue(DIV, 32'd5, 32'd0, 5'd5, 1);
    issue(REM, 32'd5, 32'd0, 5'd6, 1);
    issue(DIVU, 32'hFFFF_FFFB, 32'd0, 5'd7, 1);
    issue(REMU, 32'hFFFF_FFFB, 32'd0, 5'd8, 1);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'h1A, 1);
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'h1A, 1);
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1);
    issue(REM, 32'd7, 32'hFFFF_FFFE, 5'd10, 1);
    issue(REMU, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 5'd11, 1);
    drain();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (k % 4 == 0) ? 32'h0 : (k % 4 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      issue(div_op_e'(k % 4), a, b, 5'(k + 12), 1);
    end
    drain();
    // stall in DONE: output held, new requests ignored
    i_ready = 0;
    issue(DIV, 32'd100, 32'hFFFF_FFFD, 5'd7, 1);
    for (int n = 0; n < 40 && !o_valid; n++) tick();
    for (int n = 0; n < 5; n++) begin
      i_valid = 1;
      i_op = DIVU;
      i_dividend = 32'd9;
      i_divisor = 32'd3;
      i_tag = 5'd30;
      chk("hold_valid", {31'b0, o_valid}, 32'h1);
      chk("hold_ready", {31'b0, o_ready}, 32'h0);
      chk("hold_result", o_result, 32'hFFFF_FFDF);
      chk("hold_tag", {27'b0, o_tag}, 32'h7);
      tick();
    end
    i_valid = 0;
    i_ready = 1;
    drain();
    tick();
    // flush on third BUSY cycle
    issue(DIV, 32'd1000, 32'd3, 5'd20, 0);
    tick();
    tick();
    i_flush = 1;
    tick();
    i_flush = 0;
    chk("flush_ready", {31'b0, o_ready}, 32'h1);
    chk("flush_valid", {31'b0, o_valid}, 32'h0);
    repeat (12) tick();
    issue(DIVU, 32'd100, 32'd7, 5'd21, 1);
    drain();
    tick();
    // reset on third BUSY cycle
    issue(REM, 32'd1000, 32'd3, 5'd22, 0);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_ready", {31'b0, o_ready}, 32'h1);
    chk("rstmid_valid", {31'b0, o_valid}, 32'h0);
    chk("rstmid_result", o_result, 32'h0);
    repeat (12) tick();
    issue(DIVU, 32'd100, 32'd7, 5'd23, 1);
    drain();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
